i2c_reg_access: RTL and testbench

- Register-transaction engine between the ADV7513 configuration/monitor sequencers and the byte-level i2c_master.
- Turns one request (chip address, register address, write data or read) into the ena/busy byte handshake i2c_master expects.
- Supports single-byte register writes and single-byte register reads. Reads use a repeated start.
- Reports completion, read data and ACK failure so the sequencer can retry, or poll status registers such as 0x42 (HPD) and 0x9E (PLL lock).

---
 rtl/i2c_reg_access.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_reg_access.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_access.sv
// i2c_reg_access: register read/write transaction engine sitting between the
// ADV7513 configuration/monitor sequencers and the byte-level i2c_master.
// One request (chip, register, data, rw) becomes the ena/busy byte handshake:
// a write sends chip+W, reg, data; a read sends chip+W, reg, repeated start,
// chip+R and reads one byte.
//
// Handshake: a request is taken on the first clk where start=1 while done=1;
// done drops the next cycle and rises again when the transaction is complete.
// rd_data, ack_err and timeout are valid while done=1.
//
// Build option: define TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog that
// aborts a stuck transaction and reports timeout=1 / ack_err=1.
module i2c_reg_access #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_520_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] chip_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    input  logic       rw_req,
    input  logic       start,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       ack_err,
    output logic       timeout,
    input  logic       i2c_busy,
    input  logic       i2c_ack_error,
    input  logic [7:0] i2c_data_rd,
    output logic       i2c_ena,
    output logic [6:0] i2c_addr,
    output logic       i2c_rw,
    output logic [7:0] i2c_data_wr,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_DRAIN = 3'd0,
        S_IDLE  = 3'd1,
        S_B1    = 3'd2,
        S_B2    = 3'd3,
        S_END   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       busy_q;
    logic       done_q, done_d;
    logic       ena_q, ena_d;
    logic [6:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic [7:0] data_wr_q, data_wr_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ack_err_q, ack_err_d;
    logic       req_rw_q, req_rw_d;
    logic [7:0] req_wr_q, req_wr_d;
    logic       rise, fall;
    logic       in_xfer;

    // The master toggles busy once per latched byte; edges are taken against
    // the registered copy so each edge advances the FSM exactly once.
    assign rise    = i2c_busy & ~busy_q;
    assign fall    = ~i2c_busy & busy_q;
    assign in_xfer = (state_q == S_B1) || (state_q == S_B2) || (state_q == S_END);

`ifdef TIMEOUT_EN
    logic [23:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        expired;

    assign expired = (cnt_q == (TIMEOUT_CYCLES - 24'd1));

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= 24'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

    // State and output registers; reset returns everything to idle-draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_DRAIN;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ena_q     <= 1'b0;
            addr_q    <= 7'd0;
            rw_q      <= 1'b0;
            data_wr_q <= 8'd0;
            rd_data_q <= 8'd0;
            ack_err_q <= 1'b0;
            req_rw_q  <= 1'b0;
            req_wr_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= i2c_busy;
            done_q    <= done_d;
            ena_q     <= ena_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            data_wr_q <= data_wr_d;
            rd_data_q <= rd_data_d;
            ack_err_q <= ack_err_d;
            req_rw_q  <= req_rw_d;
            req_wr_q  <= req_wr_d;
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        ena_d     = ena_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        data_wr_d = data_wr_q;
        rd_data_d = rd_data_q;
        ack_err_d = ack_err_q;
        req_rw_d  = req_rw_q;
        req_wr_d  = req_wr_q;
`ifdef TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif

        case (state_q)
            // The master is not reset with us; let any in-flight byte finish.
            S_DRAIN: begin
                ena_d = 1'b0;
                if (!i2c_busy) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    req_rw_d  = rw_req;
                    req_wr_d  = wr_data;
                    addr_d    = chip_addr;
                    rw_d      = 1'b0;
                    data_wr_d = reg_addr;
                    ena_d     = 1'b1;
                    ack_err_d = 1'b0;
                    done_d    = 1'b0;
                    state_d   = S_B1;
`ifdef TIMEOUT_EN
                    cnt_d     = 24'd0;
                    timeout_d = 1'b0;
`endif
                end
            end
            // Register address latched: queue the data byte or the read turn.
            S_B1: begin
                if (rise) begin
                    if (req_rw_q) begin
                        rw_d = 1'b1;
                    end else begin
                        data_wr_d = req_wr_q;
                    end
                    state_d = S_B2;
                end
            end
            // Second byte latched: dropping ena makes the master stop after it.
            S_B2: begin
                if (rise) begin
                    ena_d   = 1'b0;
                    state_d = S_END;
                end
            end
            S_END: begin
                if (fall) begin
                    if (req_rw_q) begin
                        rd_data_d = i2c_data_rd;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ena_d   = 1'b0;
                state_d = S_DRAIN;
            end
        endcase

        // A NACK is sticky for the whole transaction but never cuts it short.
        if (in_xfer && fall && i2c_ack_error) begin
            ack_err_d = 1'b1;
        end

`ifdef TIMEOUT_EN
        if (in_xfer) begin
            cnt_d = cnt_q + 24'd1;
            if (expired) begin
                ena_d     = 1'b0;
                timeout_d = 1'b1;
                ack_err_d = 1'b1;
                done_d    = 1'b0;
                rd_data_d = rd_data_q;
                state_d   = S_DRAIN;
            end
        end
`endif
    end

    assign done        = done_q;
    assign rd_data     = rd_data_q;
    assign ack_err     = ack_err_q;
    assign i2c_ena     = ena_q;
    assign i2c_addr    = addr_q;
    assign i2c_rw      = rw_q;
    assign i2c_data_wr = data_wr_q;
    assign dbg_state   = state_q;
`ifdef TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_access.sv
// Testbench for i2c_reg_access. A behavioural i2c_master model logs every
// byte it puts on the bus (plus repeated-start and stop markers) into got_q;
// directed tests push the hand-computed bus sequence into exp_q and compare.
// The watchdog test runs only when TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_i2c_reg_access;

    localparam int BYTE_CYC = 20;
    localparam int GAP_CYC  = 3;
    localparam int STOP_CYC = 5;
    localparam logic [9:0] RS_MARK   = 10'h100;
    localparam logic [9:0] STOP_MARK = 10'h101;
`ifdef TIMEOUT_EN
    localparam logic [23:0] TB_TIMEOUT = 24'd1000;
`else
    localparam logic [23:0] TB_TIMEOUT = 24'd2_520_000;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] chip_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       rw_req = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] rd_data;
    logic       ack_err;
    logic       timeout;
    logic       i2c_busy = 1'b0;
    logic       i2c_ack_error = 1'b0;
    logic [7:0] i2c_data_rd = 8'd0;
    logic       i2c_ena;
    logic [6:0] i2c_addr;
    logic       i2c_rw;
    logic [7:0] i2c_data_wr;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    int         rise_cnt = 0;
    bit         model_mute = 1'b0;
    bit         nack_addr = 1'b0;
    logic [7:0] slave_rd = 8'h00;
    logic [6:0] m_addr;
    logic       m_rw;
    logic [7:0] m_data;
    bit         m_more;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    i2c_reg_access #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .chip_addr(chip_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .rw_req(rw_req), .start(start),
        .done(done), .rd_data(rd_data), .ack_err(ack_err), .timeout(timeout),
        .i2c_busy(i2c_busy), .i2c_ack_error(i2c_ack_error), .i2c_data_rd(i2c_data_rd),
        .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
        .i2c_data_wr(i2c_data_wr), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag);
        int n;
        check({tag, "_log_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_log[%0d]", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- bus model ----------------
    task automatic bus_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_addr_byte(input logic [6:0] a, input logic rw);
        got_q.push_back({2'b00, a, rw});
        bus_wait(BYTE_CYC);
        if (nack_addr) i2c_ack_error = 1'b1;
    endtask

    task automatic model_data_byte(input logic rw, input logic [7:0] d);
        if (!rw) begin
            got_q.push_back({2'b00, d});
        end else begin
            i2c_data_rd = slave_rd;
            got_q.push_back({2'b00, slave_rd});
        end
        bus_wait(BYTE_CYC);
    endtask

    initial begin : bus_model
        forever begin
            @(posedge clk);
            #1;
            if (i2c_ena && !model_mute) begin
                m_addr = i2c_addr;
                m_rw   = i2c_rw;
                m_data = i2c_data_wr;
                i2c_ack_error = 1'b0;
                i2c_busy = 1'b1;
                rise_cnt++;
                model_addr_byte(m_addr, m_rw);
                m_more = 1'b1;
                while (m_more) begin
                    model_data_byte(m_rw, m_data);
                    if (i2c_ena) begin
                        i2c_busy = 1'b0;
                        bus_wait(GAP_CYC);
                        i2c_busy = 1'b1;
                        rise_cnt++;
                        if (i2c_addr != m_addr || i2c_rw != m_rw) begin
                            got_q.push_back(RS_MARK);
                            m_addr = i2c_addr;
                            m_rw   = i2c_rw;
                            model_addr_byte(m_addr, m_rw);
                        end
                        m_data = i2c_data_wr;
                    end else begin
                        bus_wait(STOP_CYC);
                        got_q.push_back(STOP_MARK);
                        i2c_busy = 1'b0;
                        m_more = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic [6:0] ca, input logic [7:0] ra,
                          input logic [7:0] wd, input logic rw);
        @(negedge clk);
        chip_addr = ca;
        reg_addr  = ra;
        wr_data   = wd;
        rw_req    = rw;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, done, 1'b1);
    endtask

    task automatic wait_rise(input string tag, input int cnt);
        int n = 0;
        while (rise_cnt < cnt && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rise_seen"}, (rise_cnt >= cnt), 1'b1);
    endtask

    // ---------------- directed tests ----------------
    initial begin : stimulus
        int n;
        int early_done;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_done", done, 1'b0);
        check("rst_ena", i2c_ena, 1'b0);
        check("rst_addr", i2c_addr, 7'd0);
        check("rst_rw", i2c_rw, 1'b0);
        check("rst_data_wr", i2c_data_wr, 8'd0);
        check("rst_rd_data", rd_data, 8'd0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("drain_to_idle_done", done, 1'b1);

        // Register write 0x39 / 0x41 <- 0x10
        rise_cnt = 0;
        do_req(7'h39, 8'h41, 8'h10, 1'b0);
        check("wr_done_low", done, 1'b0);
        check("wr_ena_high", i2c_ena, 1'b1);
        wait_done("wr");
        exp_q.push_back(10'h072); exp_q.push_back(10'h041);
        exp_q.push_back(10'h010); exp_q.push_back(STOP_MARK);
        check_log("wr");
        check("wr_ack_err", ack_err, 1'b0);
        check("wr_timeout", timeout, 1'b0);
        check("wr_rise_cnt", rise_cnt, 2);
        check("wr_ena_low", i2c_ena, 1'b0);

        // Register read 0x39 / 0x42 -> 0x60
        rise_cnt = 0;
        slave_rd = 8'h60;
        do_req(7'h39, 8'h42, 8'h00, 1'b1);
        wait_done("rd");
        exp_q.push_back(10'h072); exp_q.push_back(10'h042);
        exp_q.push_back(RS_MARK); exp_q.push_back(10'h073);
        exp_q.push_back(10'h060); exp_q.push_back(STOP_MARK);
        check_log("rd");
        check("rd_data", rd_data, 8'h60);
        check("rd_ack_err", ack_err, 1'b0);
        check("rd_rise_cnt", rise_cnt, 2);

        // Write with the device address NACKed
        nack_addr = 1'b1;
        do_req(7'h39, 8'h10, 8'hAA, 1'b0);
        wait_done("nack");
        nack_addr = 1'b0;
        exp_q.push_back(10'h072); exp_q.push_back(10'h010);
        exp_q.push_back(10'h0AA); exp_q.push_back(STOP_MARK);
        check_log("nack");
        check("nack_ack_err", ack_err, 1'b1);
        check("nack_rd_data_held", rd_data, 8'h60);

        // Second start during S_B2 is ignored
        rise_cnt = 0;
        do_req(7'h39, 8'h41, 8'h10, 1'b0);
        wait_rise("busy_start", 1);
        repeat (4) @(negedge clk);
        do_req(7'h20, 8'h55, 8'h77, 1'b1);
        wait_done("busy_start");
        exp_q.push_back(10'h072); exp_q.push_back(10'h041);
        exp_q.push_back(10'h010); exp_q.push_back(STOP_MARK);
        check_log("busy_start");
        check("busy_start_ack_err_cleared", ack_err, 1'b0);
        repeat (40) @(negedge clk);
        check("busy_start_no_second_req", got_q.size(), 0);
        check("busy_start_idle_done", done, 1'b1);

        // Reset pulse during byte 2 (register address) of a write
        rise_cnt = 0;
        do_req(7'h39, 8'h41, 8'h10, 1'b0);
        wait_rise("mid_rst", 1);
        repeat (BYTE_CYC + 5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_ena_low", i2c_ena, 1'b0);
        check("mid_rst_done_low", done, 1'b0);
        n = 0;
        early_done = 0;
        while (i2c_busy && n < 500) begin
            @(negedge clk);
            if (done) early_done++;
            n++;
        end
        check("mid_rst_busy_released", i2c_busy, 1'b0);
        check("mid_rst_no_early_done", early_done, 0);
        check("mid_rst_done_wait", done, 1'b0);
        @(negedge clk);
        check("mid_rst_done_after_drain", done, 1'b1);
        check("mid_rst_ack_err", ack_err, 1'b0);
        exp_q.push_back(10'h072); exp_q.push_back(10'h041);
        exp_q.push_back(STOP_MARK);
        check_log("mid_rst");

`ifdef TIMEOUT_EN
        // Watchdog: master never answers, so the transaction must abort
        model_mute = 1'b1;
        do_req(7'h39, 8'h41, 8'h10, 1'b0);
        repeat (999) @(negedge clk);
        check("to_not_yet", timeout, 1'b0);
        check("to_ena_still_high", i2c_ena, 1'b1);
        @(negedge clk);
        check("to_timeout", timeout, 1'b1);
        check("to_ack_err", ack_err, 1'b1);
        check("to_ena_low", i2c_ena, 1'b0);
        check("to_done_low", done, 1'b0);
        @(negedge clk);
        check("to_done", done, 1'b1);
        model_mute = 1'b0;
        check("to_no_bus_traffic", got_q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
